// File: rtl/alut_cam30.sv
// APB-programmable MAC address lookup table with learn, age sweep and bulk clear.
// A single engine walks the table one entry per clock and posts hit/full/port/index status.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a CMD write; RW registers writable
// S_SCAN  | lookup: stop at first match; learn: record match/free index
// S_WRITE | learn commit: update matched entry, fill free slot or flag full
// S_AGE   | age sweep: bump or expire each valid entry
// S_CLEAR | invalidate entries one per cycle
module alut_cam30 #(
    parameter int DEPTH  = 16,
    parameter int PORT_W = 4,
    parameter int AGE_W  = 4
) (
    input  logic        pclk30,
    input  logic        n_p_reset30,
    input  logic        psel30,
    input  logic        penable30,
    input  logic        pwrite30,
    input  logic [6:0]  paddr30,
    input  logic [31:0] pwdata30,
    output logic [31:0] prdata30
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [8:0]       DEPTH_CNT = 9'(DEPTH);

    localparam logic [2:0] OP_LOOKUP = 3'd1;
    localparam logic [2:0] OP_LEARN  = 3'd2;
    localparam logic [2:0] OP_AGE    = 3'd3;
    localparam logic [2:0] OP_CLEAR  = 3'd4;

    localparam logic [4:0] A_CMD    = 5'd0;
    localparam logic [4:0] A_MAC_LO = 5'd1;
    localparam logic [4:0] A_MAC_HI = 5'd2;
    localparam logic [4:0] A_PORT   = 5'd3;
    localparam logic [4:0] A_STATUS = 5'd4;
    localparam logic [4:0] A_INFO   = 5'd5;
    localparam logic [4:0] A_AGELIM = 5'd6;

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_WRITE, S_AGE, S_CLEAR} state_t;

    state_t              state_q;
    logic [2:0]          op_q;
    logic [IDX_W-1:0]    idx_q;
    logic [47:0]         mac_q;
    logic [PORT_W-1:0]   port_q;
    logic [AGE_W-1:0]    age_limit_q;
    logic                busy_q;
    logic                hit_q;
    logic                full_q;
    logic [PORT_W-1:0]   res_port_q;
    logic [IDX_W-1:0]    res_idx_q;
    logic [8:0]          count_q;
    logic                match_found_q;
    logic [IDX_W-1:0]    match_idx_q;
    logic                free_found_q;
    logic [IDX_W-1:0]    free_idx_q;

    logic                valid_q    [DEPTH];
    logic [47:0]         tab_mac_q  [DEPTH];
    logic [PORT_W-1:0]   tab_port_q [DEPTH];
    logic [AGE_W-1:0]    tab_age_q  [DEPTH];

    logic       strobe;
    logic       wr_en;
    logic       cmd_go;
    logic [4:0] reg_addr;
    logic [2:0] cmd_op;
    logic       entry_match;
    logic       last_idx;
    logic       unused_addr;

    assign reg_addr    = paddr30[6:2];
    assign unused_addr = ^paddr30[1:0];
    assign strobe      = psel30 & penable30;
    assign wr_en       = strobe & pwrite30 & (state_q == S_IDLE);
    assign cmd_op      = pwdata30[2:0];
    assign cmd_go      = wr_en && (reg_addr == A_CMD) &&
                         (cmd_op == OP_LOOKUP || cmd_op == OP_LEARN ||
                          cmd_op == OP_AGE    || cmd_op == OP_CLEAR);
    assign entry_match = valid_q[idx_q] && (tab_mac_q[idx_q] == mac_q);
    assign last_idx    = (idx_q == LAST_IDX);

    always_ff @(posedge pclk30 or negedge n_p_reset30) begin
        if (!n_p_reset30) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            idx_q         <= '0;
            mac_q         <= '0;
            port_q        <= '0;
            age_limit_q   <= '1;
            busy_q        <= 1'b0;
            hit_q         <= 1'b0;
            full_q        <= 1'b0;
            res_port_q    <= '0;
            res_idx_q     <= '0;
            count_q       <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]    <= 1'b0;
                tab_mac_q[i]  <= '0;
                tab_port_q[i] <= '0;
                tab_age_q[i]  <= '0;
            end
        end else begin
            if (wr_en) begin
                case (reg_addr)
                    A_MAC_LO: mac_q[31:0]  <= pwdata30;
                    A_MAC_HI: mac_q[47:32] <= pwdata30[15:0];
                    A_PORT:   port_q       <= pwdata30[PORT_W-1:0];
                    A_AGELIM: age_limit_q  <= pwdata30[AGE_W-1:0];
                    default: ;
                endcase
            end

            case (state_q)
                S_IDLE: begin
                    if (cmd_go) begin
                        op_q          <= cmd_op;
                        busy_q        <= 1'b1;
                        hit_q         <= 1'b0;
                        full_q        <= 1'b0;
                        res_port_q    <= '0;
                        res_idx_q     <= '0;
                        idx_q         <= '0;
                        match_found_q <= 1'b0;
                        match_idx_q   <= '0;
                        free_found_q  <= 1'b0;
                        free_idx_q    <= '0;
                        case (cmd_op)
                            OP_AGE:   state_q <= S_AGE;
                            OP_CLEAR: state_q <= S_CLEAR;
                            default:  state_q <= S_SCAN;
                        endcase
                    end
                end
                S_SCAN: begin
                    if (op_q == OP_LOOKUP) begin
                        if (entry_match) begin
                            hit_q            <= 1'b1;
                            res_port_q       <= tab_port_q[idx_q];
                            res_idx_q        <= idx_q;
                            tab_age_q[idx_q] <= '0;
                            busy_q           <= 1'b0;
                            state_q          <= S_IDLE;
                        end else if (last_idx) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        // learn keeps the first match and the lowest free slot
                        if (entry_match && !match_found_q) begin
                            match_found_q <= 1'b1;
                            match_idx_q   <= idx_q;
                        end
                        if (!valid_q[idx_q] && !free_found_q) begin
                            free_found_q <= 1'b1;
                            free_idx_q   <= idx_q;
                        end
                        if (last_idx) state_q <= S_WRITE;
                        else          idx_q   <= idx_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (match_found_q) begin
                        tab_port_q[match_idx_q] <= port_q;
                        tab_age_q[match_idx_q]  <= '0;
                        hit_q                   <= 1'b1;
                        res_idx_q               <= match_idx_q;
                    end else if (free_found_q) begin
                        valid_q[free_idx_q]    <= 1'b1;
                        tab_mac_q[free_idx_q]  <= mac_q;
                        tab_port_q[free_idx_q] <= port_q;
                        tab_age_q[free_idx_q]  <= '0;
                        res_idx_q              <= free_idx_q;
                        if (count_q < DEPTH_CNT) count_q <= count_q + 9'd1;
                    end else begin
                        full_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_AGE: begin
                    if (valid_q[idx_q]) begin
                        if (tab_age_q[idx_q] == age_limit_q) begin
                            valid_q[idx_q] <= 1'b0;
                            if (count_q != 9'd0) count_q <= count_q - 9'd1;
                        end else begin
                            tab_age_q[idx_q] <= tab_age_q[idx_q] + 1'b1;
                        end
                    end
                    if (last_idx) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_CLEAR: begin
                    valid_q[idx_q] <= 1'b0;
                    if (last_idx) begin
                        count_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        prdata30 = '0;
        if (psel30 && !pwrite30) begin
            case (reg_addr)
                A_MAC_LO: prdata30 = mac_q[31:0];
                A_MAC_HI: prdata30 = {16'd0, mac_q[47:32]};
                A_PORT:   prdata30 = 32'(port_q);
                A_STATUS: prdata30 = {8'd0, 8'(res_idx_q), 8'(res_port_q), 5'd0,
                                      full_q, hit_q, busy_q};
                A_INFO:   prdata30 = {7'd0, DEPTH_CNT, 7'd0, count_q};
                A_AGELIM: prdata30 = 32'(age_limit_q);
                default:  prdata30 = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_alut_cam30.sv
// Randomised self-checking bench for alut_cam30 against a table-level reference model.
module tb_alut_cam30;
    localparam int DEPTH = 16;

    logic        pclk30 = 1'b0;
    logic        n_p_reset30 = 1'b0;
    logic        psel30 = 1'b0;
    logic        penable30 = 1'b0;
    logic        pwrite30 = 1'b0;
    logic [6:0]  paddr30 = '0;
    logic [31:0] pwdata30 = '0;
    logic [31:0] prdata30;

    int checks = 0;
    int errors = 0;

    alut_cam30 #(.DEPTH(DEPTH), .PORT_W(4), .AGE_W(4)) dut (
        .pclk30(pclk30), .n_p_reset30(n_p_reset30), .psel30(psel30),
        .penable30(penable30), .pwrite30(pwrite30), .paddr30(paddr30),
        .pwdata30(pwdata30), .prdata30(prdata30)
    );

    always #5 pclk30 = ~pclk30;

    // reference model: table contents as plain arrays
    bit          m_valid [DEPTH];
    logic [47:0] m_mac   [DEPTH];
    int          m_port  [DEPTH];
    int          m_age   [DEPTH];
    int          m_limit;
    logic [47:0] cur_mac;
    int          cur_port;
    int          exp_cyc;
    logic [31:0] exp_st;
    logic [31:0] exp_mask;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (m_valid[i]) n++;
        return n;
    endfunction

    function automatic logic [31:0] exp_info();
        return (32'(DEPTH) << 16) | 32'(m_count());
    endfunction

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0; m_mac[i] = '0; m_port[i] = 0; m_age[i] = 0;
        end
        m_limit = 15; cur_mac = '0; cur_port = 0;
    endtask

    task automatic model_cmd(input int op);
        int hit_i, free_i;
        hit_i = -1; free_i = -1;
        exp_st = '0; exp_mask = 32'h00FF_0007; exp_cyc = DEPTH;
        case (op)
            1: begin
                exp_mask = '1;
                for (int i = 0; i < DEPTH; i++)
                    if (hit_i < 0 && m_valid[i] && m_mac[i] == cur_mac) hit_i = i;
                if (hit_i >= 0) begin
                    exp_st = 32'h2 | (32'(m_port[hit_i]) << 8) | (32'(hit_i) << 16);
                    m_age[hit_i] = 0;
                    exp_cyc = hit_i + 1;
                end
            end
            2: begin
                exp_cyc = DEPTH + 1;
                for (int i = 0; i < DEPTH; i++) begin
                    if (hit_i < 0 && m_valid[i] && m_mac[i] == cur_mac) hit_i = i;
                    if (free_i < 0 && !m_valid[i]) free_i = i;
                end
                if (hit_i >= 0) begin
                    m_port[hit_i] = cur_port; m_age[hit_i] = 0;
                    exp_st = 32'h2 | (32'(hit_i) << 16);
                end else if (free_i >= 0) begin
                    m_valid[free_i] = 1; m_mac[free_i] = cur_mac;
                    m_port[free_i] = cur_port; m_age[free_i] = 0;
                    exp_st = 32'(free_i) << 16;
                end else begin
                    exp_st = 32'h4;
                end
            end
            3: begin
                for (int i = 0; i < DEPTH; i++)
                    if (m_valid[i]) begin
                        if (m_age[i] == m_limit) m_valid[i] = 0;
                        else m_age[i] = (m_age[i] + 1) % 16;
                    end
            end
            default: begin
                for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
            end
        endcase
    endtask

    task automatic apb_write(input logic [6:0] a, input logic [31:0] d);
        @(negedge pclk30);
        psel30 = 1; penable30 = 0; pwrite30 = 1; paddr30 = a; pwdata30 = d;
        @(negedge pclk30);
        penable30 = 1;
        @(posedge pclk30);
        #1;
        psel30 = 0; penable30 = 0; pwrite30 = 0;
    endtask

    // combinational read, completes without consuming a clock edge
    task automatic apb_read(input logic [6:0] a, output logic [31:0] d);
        psel30 = 1; penable30 = 0; pwrite30 = 0; paddr30 = a;
        #1;
        d = prdata30;
        psel30 = 0;
    endtask

    task automatic set_mac(input logic [47:0] m);
        apb_write(7'h04, m[31:0]);
        apb_write(7'h08, {16'd0, m[47:32]});
        cur_mac = m;
    endtask

    task automatic set_port(input int p);
        apb_write(7'h0C, 32'(p));
        cur_port = p;
    endtask

    task automatic wait_idle(output int cyc, output logic [31:0] st);
        cyc = 0;
        forever begin
            @(negedge pclk30);
            apb_read(7'h10, st);
            if (!st[0] || cyc > 200) break;
            cyc++;
        end
    endtask

    task automatic issue_cmd(input int op, output int cyc, output logic [31:0] st);
        apb_write(7'h00, 32'(op));
        wait_idle(cyc, st);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        @(negedge pclk30);
        apb_read(7'h14, d);
        checks++; if (d !== exp_info()) begin errors++; $display("FAIL reset_info got %h exp %h", d, exp_info()); end
        apb_read(7'h18, d);
        checks++; if (d !== 32'hF) begin errors++; $display("FAIL reset_agelim got %h exp %h", d, 32'hF); end
        apb_read(7'h10, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 0", d); end
        apb_read(7'h0C, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_port got %h exp 0", d); end
        paddr30 = 7'h14; psel30 = 0; #1;
        checks++; if (prdata30 !== 32'h0) begin errors++; $display("FAIL unselected_prdata got %h exp 0", prdata30); end
    endtask

    task automatic test_learn_lookup();
        int cyc; logic [31:0] st, d;
        set_mac(48'h0011_2233_4455); set_port(3);
        issue_cmd(2, cyc, st); model_cmd(2);
        checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL learn_cycles got %0d exp %0d", cyc, exp_cyc); end
        checks++; if ((st & exp_mask) !== exp_st) begin errors++; $display("FAIL learn_status got %h exp %h", st & exp_mask, exp_st); end
        apb_read(7'h14, d);
        checks++; if (d !== exp_info()) begin errors++; $display("FAIL learn_count got %h exp %h", d, exp_info()); end
        issue_cmd(1, cyc, st); model_cmd(1);
        checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL lookup_cycles got %0d exp %0d", cyc, exp_cyc); end
        checks++; if (st !== exp_st) begin errors++; $display("FAIL lookup_status got %h exp %h", st, exp_st); end
        set_port(5);
        issue_cmd(2, cyc, st); model_cmd(2);
        checks++; if ((st & exp_mask) !== exp_st) begin errors++; $display("FAIL relearn_status got %h exp %h", st & exp_mask, exp_st); end
        apb_read(7'h14, d);
        checks++; if (d !== exp_info()) begin errors++; $display("FAIL relearn_count got %h exp %h", d, exp_info()); end
        issue_cmd(1, cyc, st); model_cmd(1);
        checks++; if (st !== exp_st) begin errors++; $display("FAIL relookup_status got %h exp %h", st, exp_st); end
        set_mac(48'hDEAD_BEEF_0001);
        issue_cmd(1, cyc, st); model_cmd(1);
        checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL miss_cycles got %0d exp %0d", cyc, exp_cyc); end
        checks++; if (st !== exp_st) begin errors++; $display("FAIL miss_status got %h exp %h", st, exp_st); end
    endtask

    task automatic test_busy_ignore();
        int cyc; logic [31:0] st, d;
        set_mac(48'h1234_5678_9ABC); set_port(2);
        apb_write(7'h00, 32'd2);
        apb_write(7'h0C, 32'd7);
        apb_write(7'h00, 32'd1);
        wait_idle(cyc, st); model_cmd(2);
        checks++; if ((st & exp_mask) !== exp_st) begin errors++; $display("FAIL busy_learn_status got %h exp %h", st & exp_mask, exp_st); end
        apb_read(7'h0C, d);
        checks++; if (d !== 32'(cur_port)) begin errors++; $display("FAIL busy_port got %h exp %h", d, cur_port); end
        @(negedge pclk30);
        apb_read(7'h10, d);
        checks++; if (d[0] !== 1'b0) begin errors++; $display("FAIL busy_cmd_ignored got busy %b exp 0", d[0]); end
    endtask

    task automatic test_back_to_back();
        int cyc; logic [31:0] st;
        set_mac(48'hCAFE_0000_0042); set_port(9);
        apb_write(7'h00, 32'd2);
        wait_idle(cyc, st); model_cmd(2);
        checks++; if ((st & exp_mask) !== exp_st) begin errors++; $display("FAIL b2b_learn_status got %h exp %h", st & exp_mask, exp_st); end
        // command presented in the very cycle busy reads 0
        psel30 = 1; penable30 = 1; pwrite30 = 1; paddr30 = 7'h00; pwdata30 = 32'd1;
        @(posedge pclk30);
        #1;
        psel30 = 0; penable30 = 0; pwrite30 = 0;
        wait_idle(cyc, st); model_cmd(1);
        checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL b2b_lookup_cycles got %0d exp %0d", cyc, exp_cyc); end
        checks++; if (st !== exp_st) begin errors++; $display("FAIL b2b_lookup_status got %h exp %h", st, exp_st); end
    endtask

    task automatic test_fill_clear();
        int cyc, k; logic [31:0] st, d;
        logic [47:0] macs [DEPTH];
        issue_cmd(4, cyc, st); model_cmd(4);
        for (int i = 0; i <= DEPTH; i++) begin
            set_mac({16'hF000 | 16'(i), 32'($urandom())});
            if (i < DEPTH) macs[i] = cur_mac;
            set_port(int'($urandom_range(0, 15)));
            issue_cmd(2, cyc, st); model_cmd(2);
            checks++; if ((st & exp_mask) !== exp_st) begin errors++; $display("FAIL fill_status_%0d got %h exp %h", i, st & exp_mask, exp_st); end
        end
        apb_read(7'h14, d);
        checks++; if (d !== exp_info()) begin errors++; $display("FAIL full_count got %h exp %h", d, exp_info()); end
        for (int j = 0; j < 4; j++) begin
            k = int'($urandom_range(0, DEPTH - 1));
            set_mac(macs[k]);
            issue_cmd(1, cyc, st); model_cmd(1);
            checks++; if (cyc !== exp_cyc || st !== exp_st) begin errors++; $display("FAIL full_lookup_%0d got %0d/%h exp %0d/%h", k, cyc, st, exp_cyc, exp_st); end
        end
        issue_cmd(4, cyc, st); model_cmd(4);
        checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL clear_cycles got %0d exp %0d", cyc, exp_cyc); end
        apb_read(7'h14, d);
        checks++; if (d !== exp_info()) begin errors++; $display("FAIL clear_count got %h exp %h", d, exp_info()); end
        for (int j = 0; j < 3; j++) begin
            set_mac(macs[j * 5]);
            issue_cmd(1, cyc, st); model_cmd(1);
            checks++; if (st !== exp_st) begin errors++; $display("FAIL clear_lookup got %h exp %h", st, exp_st); end
        end
    endtask

    task automatic test_aging();
        int cyc; logic [31:0] st, d;
        apb_write(7'h18, 32'd1); m_limit = 1;
        set_mac(48'hAAAA_0000_0001); set_port(1);
        issue_cmd(2, cyc, st); model_cmd(2);
        issue_cmd(3, cyc, st); model_cmd(3);
        issue_cmd(3, cyc, st); model_cmd(3);
        checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL age_cycles got %0d exp %0d", cyc, exp_cyc); end
        apb_read(7'h14, d);
        checks++; if (d !== exp_info()) begin errors++; $display("FAIL age_removed_count got %h exp %h", d, exp_info()); end
        issue_cmd(1, cyc, st); model_cmd(1);
        checks++; if (st !== exp_st) begin errors++; $display("FAIL age_removed_lookup got %h exp %h", st, exp_st); end
        set_mac(48'hBBBB_0000_0002); set_port(6);
        issue_cmd(2, cyc, st); model_cmd(2);
        issue_cmd(3, cyc, st); model_cmd(3);
        issue_cmd(1, cyc, st); model_cmd(1);
        issue_cmd(3, cyc, st); model_cmd(3);
        issue_cmd(1, cyc, st); model_cmd(1);
        checks++; if (st !== exp_st) begin errors++; $display("FAIL age_refresh_lookup got %h exp %h", st, exp_st); end
        apb_read(7'h14, d);
        checks++; if (d !== exp_info()) begin errors++; $display("FAIL age_refresh_count got %h exp %h", d, exp_info()); end
    endtask

    task automatic test_random();
        int cyc, op, r; logic [31:0] st, d;
        logic [47:0] pool [6];
        for (int i = 0; i < 6; i++) pool[i] = 48'({$urandom(), $urandom()});
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 19));
            op = (r < 7) ? 1 : (r < 15) ? 2 : (r < 19) ? 3 : 4;
            if ($urandom_range(0, 7) == 0) begin
                m_limit = int'($urandom_range(0, 3));
                apb_write(7'h18, 32'(m_limit));
            end
            set_mac(pool[$urandom_range(0, 5)]);
            if (op == 2) set_port(int'($urandom_range(0, 15)));
            issue_cmd(op, cyc, st); model_cmd(op);
            checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL rand_cycles_%0d op %0d got %0d exp %0d", n, op, cyc, exp_cyc); end
            checks++; if ((st & exp_mask) !== exp_st) begin errors++; $display("FAIL rand_status_%0d op %0d got %h exp %h", n, op, st & exp_mask, exp_st); end
            apb_read(7'h14, d);
            checks++; if (d !== exp_info()) begin errors++; $display("FAIL rand_count_%0d got %h exp %h", n, d, exp_info()); end
        end
    endtask

    task automatic test_reset_mid();
        int cyc; logic [31:0] st, d;
        set_mac(48'h0123_4567_89AB); set_port(4);
        issue_cmd(2, cyc, st); model_cmd(2);
        set_mac(48'h0F0F_0F0F_0F0F);
        apb_write(7'h00, 32'd2);
        repeat (5) @(posedge pclk30);
        #2 n_p_reset30 = 0;
        #10 n_p_reset30 = 1;
        m_reset();
        @(negedge pclk30);
        apb_read(7'h10, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_status got %h exp 0", d); end
        apb_read(7'h14, d);
        checks++; if (d !== exp_info()) begin errors++; $display("FAIL midreset_count got %h exp %h", d, exp_info()); end
        apb_read(7'h18, d);
        checks++; if (d !== 32'hF) begin errors++; $display("FAIL midreset_agelim got %h exp %h", d, 32'hF); end
        set_mac(48'h0123_4567_89AB);
        issue_cmd(1, cyc, st); model_cmd(1);
        checks++; if (st !== exp_st || cyc !== exp_cyc) begin errors++; $display("FAIL midreset_lookup got %0d/%h exp %0d/%h", cyc, st, exp_cyc, exp_st); end
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge pclk30);
        #2 n_p_reset30 = 1;
        test_reset();
        test_learn_lookup();
        test_busy_ignore();
        test_back_to_back();
        test_fill_clear();
        test_aging();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
